// File: rtl/weight_pingpong_buffer.sv
// Double-buffered kernel weight store between the DDR weight loader and the PE mesh.
// The loader fills the shadow bank over a narrow beat stream while the PE side
// reads full X_PE x X_MESH x KSIZE kernel words from the active bank. Banks are
// exchanged on request. A swap requested mid-read waits until that read delivers.
module weight_pingpong_buffer #(
    parameter int X_PE     = 16,
    parameter int X_MESH   = 16,
    parameter int WBITS    = 8,
    parameter int KSIZE    = 9,
    parameter int DATA_LEN = 64,
    parameter int ADDR_LEN = 9
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_start,
    input  logic [ADDR_LEN-1:0]                    st_wr_addr,
    input  logic [DATA_LEN-1:0]                    data_wr,
    input  logic                                   wr_en,
    output logic                                   wr_ready,
    input  logic                                   bank_swap,
    output logic                                   active_bank,
    input  logic                                   rd_conf,
    input  logic [ADDR_LEN-1:0]                    st_rd_addr,
    input  logic                                   mode_1x1,
    output logic                                   rd_ready,
    output logic [X_PE*X_MESH*WBITS*KSIZE-1:0]     ker_out,
    output logic                                   ker_en
);

    localparam int LANES     = X_PE * X_MESH * WBITS / DATA_LEN;
    localparam int KER_W     = LANES * DATA_LEN * KSIZE;
    localparam int RAM_DEPTH = 2 ** ADDR_LEN;
    localparam int ROW_W     = LANES * DATA_LEN;
    localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TW        = (KSIZE > 1) ? $clog2(KSIZE) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Two banks of LANES narrow RAMs; a row across all lanes is one kernel tap.
    logic [DATA_LEN-1:0] mem [2][LANES][RAM_DEPTH];

    logic [ADDR_LEN-1:0] row_ptr;
    logic [LW-1:0]       lane_cnt;
    logic [ADDR_LEN-1:0] wr_row;
    logic [LW-1:0]       wr_lane;
    logic                wr_fire;

    logic [ADDR_LEN-1:0] rd_base;
    logic [ADDR_LEN-1:0] rd_row;
    logic [TW-1:0]       t_cnt;
    logic [TW-1:0]       t_last;
    logic                rd_accept;
    logic                swap_pending;

    logic [ROW_W-1:0]    tap_buf_p0 [KSIZE];
    logic                mode_p0;
    logic                vld_p0;
    logic [KER_W-1:0]    ker_asm;

    assign rd_ready  = (state == IDLE) && !swap_pending && !rst;
    assign wr_ready  = !swap_pending && !rst;
    assign rd_accept = rd_conf && rd_ready;
    assign rd_row    = rd_base + ADDR_LEN'(t_cnt);

    // A wr_start arriving with a beat places that beat at the new start row, lane 0.
    assign wr_fire = wr_en && wr_ready;
    assign wr_lane = wr_start ? '0 : lane_cnt;
    assign wr_row  = wr_start ? st_wr_addr : row_ptr;

    // Write pointer: lanes fill left to right, then the row advances (wrapping).
    always_ff @(posedge clk) begin
        if (rst) begin
            row_ptr  <= '0;
            lane_cnt <= '0;
        end else if (wr_fire) begin
            if (wr_lane == LW'(LANES - 1)) begin
                lane_cnt <= '0;
                row_ptr  <= wr_row + 1'b1;
            end else begin
                lane_cnt <= wr_lane + 1'b1;
                row_ptr  <= wr_row;
            end
        end else if (wr_start) begin
            lane_cnt <= '0;
            row_ptr  <= st_wr_addr;
        end
    end

    // Loader beats always land in the shadow bank, never the one being read.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[!active_bank][wr_lane][wr_row] <= data_wr;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Read FSM next state: stay in RD until the last tap row has been captured.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rd_accept) state_nxt = RD;
            RD:   if (t_cnt == t_last) state_nxt = IDLE;
        endcase
    end

    // Read control: latch the request, step through taps, flag the final capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_base <= '0;
            t_cnt   <= '0;
            t_last  <= '0;
            mode_p0 <= 1'b0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (rd_accept) begin
                rd_base <= st_rd_addr;
                t_cnt   <= '0;
                t_last  <= mode_1x1 ? '0 : TW'(KSIZE - 1);
                mode_p0 <= mode_1x1;
            end else if (state == RD) begin
                t_cnt <= t_cnt + 1'b1;
                if (t_cnt == t_last) vld_p0 <= 1'b1;
            end
        end
    end

    // ---- stage p0: registered RAM read straight into the tap slot ----
    // Captures row rd_base+t from every lane of the active bank into slot t.
    always_ff @(posedge clk) begin
        if (state == RD) begin
            for (int l = 0; l < LANES; l++) begin
                tap_buf_p0[t_cnt][l*DATA_LEN +: DATA_LEN] <= mem[active_bank][l][rd_row];
            end
        end
    end

    // Filter n = i*X_MESH + j is byte n of the concatenated lane row, so it sits
    // at bit n*WBITS of a tap slot; it is scattered into the PE-major output order.
    for (genvar i = 0; i < X_PE; i++) begin : g_row
        for (genvar j = 0; j < X_MESH; j++) begin : g_col
            for (genvar k = 0; k < KSIZE; k++) begin : g_tap
                if (k == 0) begin : g_t0
                    assign ker_asm[k*WBITS + j*KSIZE*WBITS + i*KSIZE*WBITS*X_MESH +: WBITS] =
                        tap_buf_p0[k][(i*X_MESH + j)*WBITS +: WBITS];
                end else begin : g_tn
                    assign ker_asm[k*WBITS + j*KSIZE*WBITS + i*KSIZE*WBITS*X_MESH +: WBITS] =
                        mode_p0 ? '0 : tap_buf_p0[k][(i*X_MESH + j)*WBITS +: WBITS];
                end
            end
        end
    end

    // ---- stage p1: kernel word presented to the PE mesh ----
    // ker_out holds its value until the next completed read.
    always_ff @(posedge clk) begin
        if (rst) begin
            ker_out <= '0;
            ker_en  <= 1'b0;
        end else begin
            ker_en <= vld_p0;
            if (vld_p0) ker_out <= ker_asm;
        end
    end

    // Bank swap: immediate when no read is in flight, else deferred to the ker_en edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_bank  <= 1'b0;
            swap_pending <= 1'b0;
        end else if (swap_pending) begin
            if (vld_p0) begin
                active_bank  <= !active_bank;
                swap_pending <= 1'b0;
            end
        end else if (bank_swap) begin
            if ((state == RD) || rd_accept) swap_pending <= 1'b1;
            else                            active_bank  <= !active_bank;
        end
    end

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Self-checking bench for weight_pingpong_buffer: randomized loads and reads
// compared against a byte-level model of both banks and the swap rules.
module tb_weight_pingpong_buffer;

    localparam int X_PE     = 16;
    localparam int X_MESH   = 16;
    localparam int WBITS    = 8;
    localparam int KSIZE    = 9;
    localparam int DATA_LEN = 64;
    localparam int ADDR_LEN = 9;
    localparam int LANES    = X_PE * X_MESH * WBITS / DATA_LEN;
    localparam int BPL      = DATA_LEN / WBITS;
    localparam int NF       = X_PE * X_MESH;
    localparam int DEPTH    = 2 ** ADDR_LEN;
    localparam int KER_W    = LANES * DATA_LEN * KSIZE;

    logic                clk;
    logic                rst;
    logic                wr_start;
    logic [ADDR_LEN-1:0] st_wr_addr;
    logic [DATA_LEN-1:0] data_wr;
    logic                wr_en;
    logic                wr_ready;
    logic                bank_swap;
    logic                active_bank;
    logic                rd_conf;
    logic [ADDR_LEN-1:0] st_rd_addr;
    logic                mode_1x1;
    logic                rd_ready;
    logic [KER_W-1:0]    ker_out;
    logic                ker_en;

    int checks;
    int failures;
    int model_act;
    logic [7:0] model_mem [2][DEPTH][NF];
    logic [KER_W-1:0] saved;

    weight_pingpong_buffer #(
        .X_PE(X_PE), .X_MESH(X_MESH), .WBITS(WBITS), .KSIZE(KSIZE),
        .DATA_LEN(DATA_LEN), .ADDR_LEN(ADDR_LEN)
    ) dut (
        .clk(clk), .rst(rst), .wr_start(wr_start), .st_wr_addr(st_wr_addr),
        .data_wr(data_wr), .wr_en(wr_en), .wr_ready(wr_ready),
        .bank_swap(bank_swap), .active_bank(active_bank), .rd_conf(rd_conf),
        .st_rd_addr(st_rd_addr), .mode_1x1(mode_1x1), .rd_ready(rd_ready),
        .ker_out(ker_out), .ker_en(ker_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected kernel from the layout rule: weight(i,j,k) at k*W + j*K*W + i*K*W*X_MESH.
    function automatic logic [KER_W-1:0] expect_ker(input int bank, input int base, input bit m1);
        logic [KER_W-1:0] v;
        v = '0;
        for (int i = 0; i < X_PE; i++)
            for (int j = 0; j < X_MESH; j++)
                for (int k = 0; k < KSIZE; k++)
                    if (k == 0 || !m1)
                        v[k*WBITS + j*KSIZE*WBITS + i*KSIZE*WBITS*X_MESH +: WBITS] =
                            model_mem[bank][(base + k) % DEPTH][i*X_MESH + j];
        return v;
    endfunction

    function automatic int count_bad(input logic [KER_W-1:0] a, input logic [KER_W-1:0] b);
        int cnt;
        cnt = 0;
        for (int w = 0; w < NF * KSIZE; w++)
            if (a[w*WBITS +: WBITS] !== b[w*WBITS +: WBITS]) cnt++;
        return cnt;
    endfunction

    // Beat b after the start goes to row start + b/LANES, lane b%LANES of the shadow bank.
    task automatic write_set(input int start, input bit use_start, input bit pattern,
                             input int nbeats, input string tag);
        int sh;
        int b;
        int row;
        int lane;
        logic [63:0] d;
        sh = 1 - model_act;
        b = 0;
        chk({tag, "_wr_ready"}, 64'(wr_ready), 64'd1);
        while (b < nbeats) begin
            if (b > 0 && $urandom_range(0, 4) == 0) begin
                wr_en = 1'b0;
                wr_start = 1'b0;
                data_wr = {$urandom, $urandom};
                tick;
            end else begin
                for (int m = 0; m < BPL; m++)
                    d[m*8 +: 8] = pattern ? 8'((b + m) % 256) : 8'($urandom);
                data_wr = d;
                wr_en = 1'b1;
                wr_start = use_start && (b == 0);
                st_wr_addr = ADDR_LEN'(start);
                tick;
                row = (start + b / LANES) % DEPTH;
                lane = b % LANES;
                for (int m = 0; m < BPL; m++)
                    model_mem[sh][row][lane*BPL + m] = d[m*8 +: 8];
                b++;
            end
        end
        wr_en = 1'b0;
        wr_start = 1'b0;
    endtask

    task automatic do_swap(input string tag);
        chk({tag, "_idle"}, 64'(rd_ready), 64'd1);
        bank_swap = 1'b1;
        tick;
        bank_swap = 1'b0;
        model_act = 1 - model_act;
        chk({tag, "_bank"}, 64'(active_bank), 64'(model_act));
    endtask

    // One read; sw1/sw2 are edges (relative to acceptance) at which bank_swap is sampled.
    task automatic run_read(input int base, input bit m1, input int sw1, input int sw2,
                            input string tag);
        int t;
        int old;
        int got_e;
        int n_en;
        logic [KER_W-1:0] exp;
        t = m1 ? 1 : KSIZE;
        old = model_act;
        got_e = -1;
        n_en = 0;
        exp = expect_ker(old, base, m1);
        chk({tag, "_rdy_pre"}, 64'(rd_ready), 64'd1);
        rd_conf = 1'b1;
        st_rd_addr = ADDR_LEN'(base);
        mode_1x1 = m1;
        bank_swap = (sw1 == 0);
        tick;
        rd_conf = 1'b0;
        mode_1x1 = 1'($urandom);
        st_rd_addr = ADDR_LEN'($urandom);
        bank_swap = 1'b0;
        chk({tag, "_rdy_busy"}, 64'(rd_ready), 64'd0);
        for (int e = 1; e <= t + 3; e++) begin
            bank_swap = (e == sw1) || (e == sw2);
            tick;
            bank_swap = 1'b0;
            if (ker_en) begin
                n_en++;
                got_e = e;
                chk({tag, "_ker_bad"}, 64'(count_bad(ker_out, exp)), 64'd0);
                chk({tag, "_rdy_at_en"}, 64'(rd_ready), 64'd1);
            end
            if (sw1 >= 0 && e >= sw1 && e <= t) begin
                chk({tag, "_bank_held"}, 64'(active_bank), 64'(old));
                chk({tag, "_wr_blocked"}, 64'(wr_ready), 64'd0);
                chk({tag, "_rd_blocked"}, 64'(rd_ready), 64'd0);
            end
        end
        chk({tag, "_en_count"}, 64'(n_en), 64'd1);
        chk({tag, "_en_edge"}, 64'(got_e), 64'(t + 1));
        if (sw1 >= 0) model_act = 1 - old;
        chk({tag, "_bank_after"}, 64'(active_bank), 64'(model_act));
        chk({tag, "_ker_hold"}, 64'(count_bad(ker_out, exp)), 64'd0);
    endtask

    // Full read followed by a 1x1 read accepted as soon as rd_ready returns.
    task automatic run_b2b(input int base1, input int base2);
        logic [KER_W-1:0] exp1;
        logic [KER_W-1:0] exp2;
        int issued;
        int acc_e;
        int n_en;
        exp1 = expect_ker(model_act, base1, 1'b0);
        exp2 = expect_ker(model_act, base2, 1'b1);
        issued = 0;
        acc_e = -1;
        n_en = 0;
        rd_conf = 1'b1;
        st_rd_addr = ADDR_LEN'(base1);
        mode_1x1 = 1'b0;
        tick;
        rd_conf = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            if (issued == 0 && rd_ready) begin
                rd_conf = 1'b1;
                st_rd_addr = ADDR_LEN'(base2);
                mode_1x1 = 1'b1;
                issued = 1;
                acc_e = e;
            end
            tick;
            rd_conf = 1'b0;
            mode_1x1 = 1'b0;
            if (ker_en) begin
                n_en++;
                if (n_en == 1) begin
                    chk("b2b_first_edge", 64'(e), 64'(KSIZE + 1));
                    chk("b2b_first_ker", 64'(count_bad(ker_out, exp1)), 64'd0);
                end else begin
                    chk("b2b_second_edge", 64'(e), 64'(acc_e + 2));
                    chk("b2b_second_ker", 64'(count_bad(ker_out, exp2)), 64'd0);
                end
            end
        end
        chk("b2b_accept_edge", 64'(acc_e), 64'(KSIZE + 1));
        chk("b2b_en_count", 64'(n_en), 64'd2);
    endtask

    initial begin
        int nz;
        int n_en;
        int start;
        int base;
        int sw;
        bit m1;
        checks = 0;
        failures = 0;
        model_act = 0;
        rst = 1'b1;
        wr_start = 1'b0;
        st_wr_addr = '0;
        data_wr = '0;
        wr_en = 1'b0;
        bank_swap = 1'b0;
        rd_conf = 1'b0;
        st_rd_addr = '0;
        mode_1x1 = 1'b0;

        repeat (3) tick;
        chk("rst_ker_en", 64'(ker_en), 64'd0);
        chk("rst_ker_out_zero", 64'(ker_out == '0), 64'd1);
        chk("rst_active_bank", 64'(active_bank), 64'd0);
        chk("rst_rd_ready", 64'(rd_ready), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        rst = 1'b0;
        tick;
        chk("post_rst_rd_ready", 64'(rd_ready), 64'd1);
        chk("post_rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("post_rst_ker_en", 64'(ker_en), 64'd0);

        // Byte m of beat b = (b+m) mod 256 into bank 1, then read row 0.
        write_set(0, 1'b1, 1'b1, LANES * KSIZE, "load_pat");
        do_swap("swap_pat");
        run_read(0, 1'b0, -1, -1, "rd_pat");
        chk("w_n0_k8", 64'(ker_out[(0*KSIZE + 8)*WBITS +: WBITS]), 64'h00);
        chk("w_n9_k1", 64'(ker_out[(9*KSIZE + 1)*WBITS +: WBITS]), 64'd34);
        chk("w_n255_k0", 64'(ker_out[(255*KSIZE + 0)*WBITS +: WBITS]), 64'd38);

        // Shadow bank 0 gets rows 508..511 and 0..4.
        write_set(DEPTH - 4, 1'b1, 1'b0, LANES * KSIZE, "load_wrap");

        run_read(3, 1'b1, -1, -1, "rd_1x1");
        nz = 0;
        for (int w = 0; w < NF; w++)
            for (int k = 1; k < KSIZE; k++)
                if (ker_out[(w*KSIZE + k)*WBITS +: WBITS] !== 8'h00) nz++;
        chk("1x1_upper_taps_zero", 64'(nz), 64'd0);

        run_read(0, 1'b0, 3, 6, "rd_defer");
        run_read(DEPTH - 4, 1'b0, -1, -1, "rd_wrap");
        run_b2b(DEPTH - 4, 2);

        run_read(DEPTH - 4, 1'b0, -1, -1, "rd_pre_rst");
        saved = ker_out;

        // Reset lands on edge 5 of a read that also has a swap pending.
        rd_conf = 1'b1;
        st_rd_addr = ADDR_LEN'(DEPTH - 4);
        mode_1x1 = 1'b0;
        tick;
        rd_conf = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            bank_swap = (e == 3);
            if (e == 5) rst = 1'b1;
            tick;
            bank_swap = 1'b0;
            if (e == 4) chk("rst_rd_pending_wr", 64'(wr_ready), 64'd0);
        end
        chk("rst_rd_ker_en", 64'(ker_en), 64'd0);
        chk("rst_rd_ker_out_zero", 64'(ker_out == '0), 64'd1);
        chk("rst_rd_bank", 64'(active_bank), 64'd0);
        chk("rst_rd_rd_ready", 64'(rd_ready), 64'd0);
        tick;
        rst = 1'b0;
        model_act = 0;
        n_en = 0;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (ker_en) n_en++;
        end
        chk("rst_rd_no_en", 64'(n_en), 64'd0);
        chk("rst_rd_out_still_zero", 64'(ker_out == '0), 64'd1);
        chk("rst_rd_bank_after", 64'(active_bank), 64'd0);
        chk("rst_rd_wr_ready", 64'(wr_ready), 64'd1);

        run_read(DEPTH - 4, 1'b0, -1, -1, "rd_post_rst");
        chk("post_rst_same_data", 64'(count_bad(ker_out, saved)), 64'd0);

        // Write pointer must restart at row 0, lane 0 after reset.
        write_set(0, 1'b0, 1'b0, LANES * KSIZE, "load_noptr");
        do_swap("swap_noptr");
        run_read(0, 1'b0, -1, -1, "rd_ptr0");

        for (int r = 0; r < 3; r++) begin
            start = $urandom_range(0, DEPTH - 1);
            write_set(start, 1'b1, 1'b0, LANES * KSIZE, "load_rnd");
            do_swap("swap_rnd");
            m1 = 1'($urandom_range(0, 1));
            base = m1 ? (start + $urandom_range(0, KSIZE - 1)) % DEPTH : start;
            sw = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, m1 ? 1 : KSIZE);
            run_read(base, m1, sw, (sw >= 0) ? sw + 1 : -1, "rd_rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
